// File: rtl/mult_seq_param_if.sv
// Operand/result handshake bundle for mult_seq_param.
// The requester drives the master side; the multiplier is the slave.
interface mult_seq_param_if #(
  parameter int WIDTH = 8
);
  logic                 START;
  logic                 SIGNED_MODE;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   PR;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output START, SIGNED_MODE, A, B,
    input  PR, BUSY, DONE
  );

  modport slave (
    input  START, SIGNED_MODE, A, B,
    output PR, BUSY, DONE
  );
endinterface

// File: rtl/mult_seq_param.sv
// Radix-2 shift-and-add multiplier, one multiplier bit per clock.
// Signed mode multiplies magnitudes and fixes the sign in a final FIX cycle.
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  mult_seq_param_if.slave    bus
);
  localparam int SW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [WIDTH-1:0]   ma_reg, ma_next;
  logic [WIDTH-1:0]   mb_reg, mb_next;
  logic               neg_reg, neg_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] pr_reg, pr_next;
  logic [SW-1:0]      step_reg, step_next;

  logic               accept;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] addend;

  assign accept = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && bus.START;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
  assign a_mag = (bus.SIGNED_MODE && bus.A[WIDTH-1]) ?
                 ((~bus.A) + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.A;
  assign b_mag = (bus.SIGNED_MODE && bus.B[WIDTH-1]) ?
                 ((~bus.B) + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.B;

  assign addend = {{WIDTH{1'b0}}, ma_reg} << step_reg;

  always_comb begin
    state_next = state_reg;
    ma_next    = ma_reg;
    mb_next    = mb_reg;
    neg_next   = neg_reg;
    acc_next   = acc_reg;
    pr_next    = pr_reg;
    step_next  = step_reg;

    if (accept) begin
      ma_next    = a_mag;
      mb_next    = b_mag;
      neg_next   = bus.SIGNED_MODE && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      acc_next   = '0;
      step_next  = '0;
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (mb_reg[0]) begin
            acc_next = acc_reg + addend;
          end
          mb_next   = mb_reg >> 1;
          step_next = step_reg + SW'(1);
          if (step_reg == SW'(WIDTH - 1)) begin
            state_next = ST_FIX;
          end
        end
        ST_FIX: begin
          pr_next    = neg_reg ? ((~acc_reg) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_reg;
          state_next = ST_DONE;
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= ST_IDLE;
      ma_reg    <= '0;
      mb_reg    <= '0;
      neg_reg   <= 1'b0;
      acc_reg   <= '0;
      pr_reg    <= '0;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ma_reg    <= ma_next;
      mb_reg    <= mb_next;
      neg_reg   <= neg_next;
      acc_reg   <= acc_next;
      pr_reg    <= pr_next;
      step_reg  <= step_next;
    end
  end

  assign bus.PR   = pr_reg;
  assign bus.BUSY = (state_reg == ST_RUN) || (state_reg == ST_FIX);
  assign bus.DONE = (state_reg == ST_DONE);
endmodule
